// File: rtl/acq_seq_pkg.sv
// Shared types for the acquisition trigger sequencer: FSM state encoding and
// the stop-reason codes reported on STOP_REASON.
package acq_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    QSTART = 3'd1,
    WSTART = 3'd2,
    QSTOP  = 3'd3,
    ACQ    = 3'd4
  } acq_state_e;

  localparam logic [1:0] RSN_COUNT = 2'b00;
  localparam logic [1:0] RSN_FULL  = 2'b01;
  localparam logic [1:0] RSN_TMO   = 2'b10;
  localparam logic [1:0] RSN_ABORT = 2'b11;

endpackage

// File: rtl/acq_evt_edge.sv
// Rising-edge detector for the event sources; the previous-level register
// runs in every state so a level already high at arming never matches.
module acq_evt_edge #(
  parameter int NUM_EVT = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_EVT-1:0] evt_i,
  output logic [NUM_EVT-1:0] pulse_o
);

  logic [NUM_EVT-1:0] evt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_i;
    end
  end

  assign pulse_o = evt_i & ~evt_q;

endmodule

// File: rtl/acq_trigger_sequencer.sv
// Acquisition start/stop sequencer: masked event counting with optional
// qualifiers, wait timeout, RAM-full stop, abort and a stop-reason code.
module acq_trigger_sequencer
  import acq_seq_pkg::*;
#(
  parameter int NUM_EVT   = 4,
  parameter int CNT_WIDTH = 8,
  parameter int TMO_WIDTH = 16
) (
  input  logic                 CLK_MASTER,
  input  logic                 RESET,
  input  logic                 CKE_500US,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [NUM_EVT-1:0]   EVT_IN,
  input  logic [NUM_EVT-1:0]   START_MASK,
  input  logic [NUM_EVT-1:0]   STOP_MASK,
  input  logic [CNT_WIDTH-1:0] START_NUM,
  input  logic [CNT_WIDTH-1:0] STOP_NUM,
  input  logic                 START_QUAL_EN,
  input  logic                 STOP_QUAL_EN,
  input  logic                 QUAL_START,
  input  logic                 QUAL_STOP,
  input  logic [TMO_WIDTH-1:0] TMO_LIMIT,
  input  logic                 SR_R_FULL,
  output logic                 WAITING,
  output logic                 ACQUIRING,
  output logic                 DONE,
  output logic [1:0]           STOP_REASON
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TMO_WIDTH-1:0] TMO_ONE = {{(TMO_WIDTH-1){1'b0}}, 1'b1};

  acq_state_e           state_q;
  logic [CNT_WIDTH-1:0] scnt_q;
  logic [CNT_WIDTH-1:0] ecnt_q;
  logic [TMO_WIDTH-1:0] tmo_q;
  logic                 done_q;
  logic [1:0]           reason_q;

  logic [NUM_EVT-1:0]   evt_pulse;
  logic                 start_match;
  logic                 start_free;
  logic                 stop_hit;
  logic                 tmo_hit;
  logic                 tmo_step;
  acq_state_e           acq_entry;

  acq_evt_edge #(
    .NUM_EVT (NUM_EVT)
  ) u_evt_edge (
    .clk_i   (CLK_MASTER),
    .rst_i   (RESET),
    .evt_i   (EVT_IN),
    .pulse_o (evt_pulse)
  );

  // Simultaneous source bits collapse into a single event via the OR-reduce.
  assign start_match = |(evt_pulse & START_MASK);
  assign start_free  = (START_MASK == '0);
  assign stop_hit    = (|(evt_pulse & STOP_MASK)) || (STOP_MASK == '0);
  assign tmo_hit     = (TMO_LIMIT != '0) && (tmo_q == TMO_LIMIT);
  assign tmo_step    = CKE_500US && (tmo_q != '1);
  assign acq_entry   = STOP_QUAL_EN ? QSTOP : ACQ;

  always_ff @(posedge CLK_MASTER) begin
    if (RESET) begin
      state_q  <= IDLE;
      scnt_q   <= '0;
      ecnt_q   <= '0;
      tmo_q    <= '0;
      done_q   <= 1'b0;
      reason_q <= RSN_COUNT;
    end else begin
      done_q <= 1'b0;
      if (ABORT && (state_q != IDLE)) begin
        state_q  <= IDLE;
        done_q   <= 1'b1;
        reason_q <= RSN_ABORT;
      end else begin
        case (state_q)
          IDLE: begin
            if (START && !ABORT) begin
              scnt_q  <= START_NUM;
              ecnt_q  <= STOP_NUM;
              tmo_q   <= '0;
              state_q <= START_QUAL_EN ? QSTART : WSTART;
            end
          end
          QSTART: begin
            if (tmo_hit) begin
              state_q  <= IDLE;
              done_q   <= 1'b1;
              reason_q <= RSN_TMO;
            end else begin
              if (tmo_step) tmo_q <= tmo_q + TMO_ONE;
              if (QUAL_START) state_q <= WSTART;
            end
          end
          WSTART: begin
            if (tmo_hit) begin
              state_q  <= IDLE;
              done_q   <= 1'b1;
              reason_q <= RSN_TMO;
            end else begin
              if (tmo_step) tmo_q <= tmo_q + TMO_ONE;
              if (start_free) begin
                state_q <= acq_entry;
              end else if (start_match) begin
                if (scnt_q != '0) scnt_q <= scnt_q - CNT_ONE;
                else              state_q <= acq_entry;
              end
            end
          end
          QSTOP: begin
            if (SR_R_FULL) begin
              state_q  <= IDLE;
              done_q   <= 1'b1;
              reason_q <= RSN_FULL;
            end else if (QUAL_STOP) begin
              state_q <= ACQ;
            end
          end
          ACQ: begin
            // RAM full takes precedence over a stop event in the same cycle.
            if (SR_R_FULL) begin
              state_q  <= IDLE;
              done_q   <= 1'b1;
              reason_q <= RSN_FULL;
            end else if (stop_hit) begin
              if (ecnt_q != '0) begin
                ecnt_q <= ecnt_q - CNT_ONE;
              end else begin
                state_q  <= IDLE;
                done_q   <= 1'b1;
                reason_q <= RSN_COUNT;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign WAITING     = (state_q == QSTART) || (state_q == WSTART);
  assign ACQUIRING   = (state_q == QSTOP)  || (state_q == ACQ);
  assign DONE        = done_q;
  assign STOP_REASON = reason_q;

endmodule

// File: doc/acq_trigger_sequencer.md
Name: acq_trigger_sequencer

Overview:
- Parametrised next-generation acquisition start/stop sequencer for the DiscFerret acquisition path, clocked by CLK_MASTER.
- Generalises the fixed index/sync-word trigger scheme to NUM_EVT masked event sources, each with its own one-cycle edge pulse.
- Adds separate arming qualifiers for start and stop, a wait timeout, RAM-full forced stop, a stop-reason code and a completion pulse.

Parameters:
- NUM_EVT, 4, number of event sources (bit 0 index, bit 1 sync-word start/stop, others spare); minimum 1.
- CNT_WIDTH, 8, width of the start/stop event counters.
- TMO_WIDTH, 16, width of the timeout counter, in CKE_500US ticks.

Ports:
- CLK_MASTER  in  1  master clock.
- RESET  in  1  synchronous, active-high reset.
- CKE_500US  in  1  one-cycle clock enable, one pulse per 500us.
- START  in  1  level; arms a sequence when the FSM is IDLE.
- ABORT  in  1  level; returns the FSM to IDLE.
- EVT_IN  in  NUM_EVT  event levels, already synchronous to CLK_MASTER.
- START_MASK  in  NUM_EVT  start event enables.
- STOP_MASK  in  NUM_EVT  stop event enables.
- START_NUM  in  CNT_WIDTH  start events to skip.
- STOP_NUM  in  CNT_WIDTH  stop events to skip.
- START_QUAL_EN  in  1  wait for QUAL_START before the start wait.
- STOP_QUAL_EN  in  1  wait for QUAL_STOP before the stop count.
- QUAL_START  in  1  start qualifier pulse (track-mark detect).
- QUAL_STOP  in  1  stop qualifier pulse.
- TMO_LIMIT  in  TMO_WIDTH  wait timeout in ticks; 0 disables it.
- SR_R_FULL  in  1  sample RAM full.
- WAITING  out  1  high in QSTART or WSTART.
- ACQUIRING  out  1  high in QSTOP or ACQ.
- DONE  out  1  one-cycle pulse when a sequence ends.
- STOP_REASON  out  2  00 count, 01 full, 10 timeout, 11 abort; holds until the next DONE.

Behaviour:
- Reset: FSM=IDLE; counters, edge registers, DONE and STOP_REASON are 0.
- Edge detect: EVT_PULSE[i] = EVT_IN[i] & ~EVT_IN_d[i] (registered previous value), so a start/stop match appears 1 cycle after the EVT_IN rise.
- Start match = |(EVT_PULSE & START_MASK). Stop match = |(EVT_PULSE & STOP_MASK).
- Several source bits firing in the same cycle count as one event.
- States:
  - IDLE: on START & ~ABORT, load SCNT=START_NUM, ECNT=STOP_NUM and TMO=0; go to QSTART if START_QUAL_EN, else WSTART.
  - QSTART: on QUAL_START go to WSTART.
  - WSTART: if START_MASK==0, leave on the next cycle. Otherwise, on a start match: if SCNT!=0 decrement it; else go to QSTOP if STOP_QUAL_EN, else ACQ. Acquisition therefore begins on start event START_NUM+1.
  - QSTOP: on QUAL_STOP go to ACQ.
  - ACQ: on a stop match (or STOP_MASK==0), if ECNT!=0 decrement it; else go to IDLE with reason 00. SR_R_FULL in ACQ or QSTOP goes to IDLE with reason 01 immediately, and beats a same-cycle stop match.
- Timeout: TMO increments on CKE_500US while in QSTART or WSTART and saturates at all-ones. When TMO_LIMIT!=0 and TMO==TMO_LIMIT, go to IDLE with reason 10. TMO does not run in ACQ.
- ABORT: from any non-IDLE state, go to IDLE with reason 11 and pulse DONE. ABORT beats START and every other event in the same cycle. ABORT while IDLE gives no DONE and no reason update.
- DONE: asserted for exactly the 1 cycle after the transition into IDLE from a non-IDLE state; STOP_REASON updates in that same cycle.
- START: ignored while not IDLE. If START is still high when the FSM returns to IDLE, it re-arms after 1 IDLE cycle (DONE-cycle IDLE).
- Mask, NUM, qualifier-enable and TMO_LIMIT inputs are sampled only via counter loads and live comparisons; firmware changes them only while IDLE.
- Counter decrements never wrap (guarded by !=0).
- Illegal state encoding goes to IDLE with no DONE.

Decomposition:
- Package acq_seq_pkg holds:
  - the state enum: IDLE, QSTART, WSTART, QSTOP, ACQ;
  - the STOP_REASON localparams: RSN_COUNT, RSN_FULL, RSN_TMO, RSN_ABORT.
- One sub-module, acq_evt_edge: NUM_EVT-wide rising-edge pulse generator with synchronous reset.

Test Plan:
- START_MASK=0001, START_NUM=2, STOP_MASK=0001, STOP_NUM=0; pulse EVT_IN[0] 4 times -> WAITING through 3 pulses, ACQUIRING 1 cycle after the 3rd pulse's rise, DONE with reason 00 after the 4th.
- START_QUAL_EN=1, events before QUAL_START -> events ignored; after QUAL_START, the 1st masked event starts ACQ.
- ACQ with STOP_NUM=5; SR_R_FULL and a stop match in the same cycle -> IDLE next cycle, DONE=1 for 1 cycle, reason 01.
- TMO_LIMIT=3, no events -> after the 3rd CKE_500US tick, DONE and reason 10; TMO_LIMIT=0 -> waits indefinitely.
- ABORT and START high in IDLE together -> stays IDLE, no DONE; ABORT during ACQ -> DONE, reason 11.
- EVT_IN[1] held high across arming -> no match until it falls and rises again; EVT_IN[0] and EVT_IN[1] rising together with both masked and START_NUM=1 -> counts as a single event.
